// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron scheduler.
package lif_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } lif_sched_state_e;

  localparam int LIF_WIDTH      = 8;
  localparam int LIF_LEAK_SHIFT = 1;

  // Unsigned add of two operands of width w (w < 32), clamped to 2^w-1.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    return (s > m) ? m : s;
  endfunction

endpackage

// File: rtl/lif_spike_fifo.sv
// Small synchronous FIFO for spike ids. DEPTH must be a power of two >= 2.
// A push while full is accepted when a pop happens in the same cycle.
module lif_spike_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);
  // Head is forced to zero when empty so the id output is defined.
  assign data_o  = empty_o ? '0 : mem[rd_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are only observed while non-empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= data_i;
  end

endmodule

// File: rtl/lif_sched.sv
// Time-multiplexed leaky integrate-and-fire scheduler: one update datapath
// walks all neurons once per tick and queues spike ids in a small FIFO.
// Optional refractory counters: define LIF_SCHED_REFRACTORY_EN.
module lif_sched
  import lif_pkg::*;
#(
  parameter int N_NEURONS     = 4,
  parameter int WIDTH         = LIF_WIDTH,
  parameter int LEAK_SHIFT    = LIF_LEAK_SHIFT,
  parameter int FIFO_DEPTH    = 4,
  parameter int REFRAC_SWEEPS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]             cfg_data,
  input  logic [WIDTH-1:0]             threshold,
  output logic                         busy,
  output logic                         sweep_done,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [$clog2(N_NEURONS)-1:0] spike_id,
  output logic [WIDTH-1:0]             state_mon,
  output logic                         drop_sticky
);

  localparam int IDW = $clog2(N_NEURONS);

  lif_sched_state_e fsm_q, fsm_d;
  logic [IDW-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0] state_q [N_NEURONS];
  logic [WIDTH-1:0] cur_q   [N_NEURONS];

  logic [WIDTH-1:0] st_sel;
  logic [WIDTH-1:0] cur_sel;
  logic [WIDTH-1:0] leaked;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] new_state;
  logic             update;
  logic             in_refrac;
  logic             fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop_q;

  assign busy        = (fsm_q == ST_SWEEP);
  assign sweep_done  = (fsm_q == ST_DONE);
  assign update      = busy;
  assign spike_valid = !fifo_empty;
  assign drop_sticky = drop_q;
  assign state_mon   = state_q[cfg_addr];

  // Shared LIF datapath for the neuron selected by idx.
  always_comb begin
    st_sel    = state_q[idx_q];
    cur_sel   = cur_q[idx_q];
    leaked    = st_sel - (st_sel >> LEAK_SHIFT);
    sum       = WIDTH'(sat_add(32'(leaked), 32'(cur_sel), WIDTH));
    fire      = update && !in_refrac && (sum >= threshold);
    new_state = (fire || in_refrac) ? '0 : sum;
  end

  // Sweep controller next-state; ticks outside IDLE are dropped.
  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    case (fsm_q)
      ST_IDLE: begin
        if (tick) begin
          fsm_d = ST_SWEEP;
          idx_d = '0;
        end
      end
      ST_SWEEP: begin
        if (idx_q == IDW'(N_NEURONS - 1)) fsm_d = ST_DONE;
        else                              idx_d = idx_q + IDW'(1);
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Sweep controller registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
    end
  end

  // Membrane and current register files; the update reads the old current
  // even when a config write targets the same neuron this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        cur_q[i]   <= '0;
      end
    end else begin
      if (cfg_we) cur_q[cfg_addr] <= cfg_data;
      if (update) state_q[idx_q]  <= new_state;
    end
  end

`ifdef LIF_SCHED_REFRACTORY_EN
  // Counter width kept at least one bit so REFRAC_SWEEPS = 0 still elaborates.
  localparam int RW = (REFRAC_SWEEPS > 0) ? $clog2(REFRAC_SWEEPS + 1) : 1;

  logic [RW-1:0] refrac_q [N_NEURONS];

  assign in_refrac = (refrac_q[idx_q] != '0);

  // Refractory counters: loaded on a spike, counted down on skipped updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
    end else if (update) begin
      if (in_refrac)  refrac_q[idx_q] <= refrac_q[idx_q] - RW'(1);
      else if (fire)  refrac_q[idx_q] <= RW'(REFRAC_SWEEPS);
    end
  end
`else
  assign in_refrac = 1'b0;
`endif

  // Sticky flag for spikes lost to a full FIFO with no pop that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= 1'b0;
    else if (fire && fifo_full && !spike_ready) drop_q <= 1'b1;
  end

  lif_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (IDW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fire),
    .pop_i   (spike_ready),
    .data_i  (idx_q),
    .data_o  (spike_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_lif_sched.sv
// Bench for lif_sched: table of per-sweep vectors plus hand sequences,
// with a spike-id scoreboard compared at every FIFO pop.
module tb_lif_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [7:0] threshold = 8'd200;
  logic       spike_ready = 1'b1;
  logic       busy, sweep_done, spike_valid, drop_sticky;
  logic [1:0] spike_id;
  logic [7:0] state_mon;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] addr;
    logic [7:0] cur;
    logic [7:0] thr;
    logic [7:0] exp_state;
    logic [3:0] mask;
  } vec_t;

  vec_t vecs[11];

  lif_sched dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .threshold   (threshold),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_id    (spike_id),
    .state_mon   (state_mon),
    .drop_sticky (drop_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: every pop is compared against the oldest expected spike.
  always @(negedge clk) begin
    if (!rst && spike_valid && spike_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_spike actual=%0d required=none", spike_id);
      end else begin
        check("spike_id", 32'(spike_id), 32'(exp_q.pop_front()));
        $display("pop spike id=%0d", spike_id);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; tick = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    threshold = 8'd200; spike_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    check("rst_spike_valid", 32'(spike_valid), 0);
    check("rst_spike_id", 32'(spike_id), 0);
    check("rst_state_mon", 32'(state_mon), 0);
    check("rst_drop", 32'(drop_sticky), 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic write_cur(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sweep_done) break;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL sweep_timeout actual=no_done required=done");
    end
    @(posedge clk); #1;
  endtask

  task automatic run_sweep();
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    wait_done();
  endtask

  task automatic check_state(input logic [1:0] a, input logic [7:0] exp, input string name);
    cfg_addr = a;
    #1 check(name, 32'(state_mon), 32'(exp));
  endtask

  initial begin
    vecs[0]  = '{2'd0, 8'd128, 8'd200, 8'd128, 4'b0000};
    vecs[1]  = '{2'd0, 8'd128, 8'd200, 8'd192, 4'b0000};
    vecs[2]  = '{2'd0, 8'd128, 8'd200, 8'd0,   4'b0001};
    vecs[3]  = '{2'd1, 8'd200, 8'd255, 8'd200, 4'b0000};
    vecs[4]  = '{2'd1, 8'd255, 8'd255, 8'd0,   4'b0010};
    vecs[5]  = '{2'd1, 8'd0,   8'd0,   8'd0,   4'b1111};
    vecs[6]  = '{2'd0, 8'd10,  8'd200, 8'd10,  4'b0000};
    vecs[7]  = '{2'd0, 8'd10,  8'd15,  8'd0,   4'b0001};
    vecs[8]  = '{2'd0, 8'd10,  8'd11,  8'd10,  4'b0000};
    vecs[9]  = '{2'd3, 8'd1,   8'd200, 8'd1,   4'b0000};
    vecs[10] = '{2'd3, 8'd0,   8'd200, 8'd1,   4'b0000};

    // Reset, then idle with no tick.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
    end
    @(posedge clk); #1;

`ifndef LIF_SCHED_REFRACTORY_EN
    // Table of sweeps: integration, leak, saturation, threshold boundaries.
    for (int v = 0; v < 11; v++) begin
      write_cur(vecs[v].addr, vecs[v].cur);
      threshold = vecs[v].thr;
      for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) exp_q.push_back(i);
      run_sweep();
      check_state(vecs[v].addr, vecs[v].exp_state, "vec_state");
      check("vec_drained", 32'(exp_q.size()), 0);
      $display("vec %0d addr=%0d cur=%0d thr=%0d state=%0d", v, vecs[v].addr,
               vecs[v].cur, vecs[v].thr, state_mon);
    end

    // FIFO fill, stable head, push-with-pop on full, then drops.
    do_reset();
    spike_ready = 1'b0;
    threshold = 8'd1;
    for (int i = 0; i < 4; i++) write_cur(2'(i), 8'd255);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    run_sweep();
    check("fill_drop", 32'(drop_sticky), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("head_valid", 32'(spike_valid), 1);
      check("head_id_stable", 32'(spike_id), 0);
    end
    @(posedge clk); #1;
    exp_q.push_back(0);
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0; spike_ready = 1'b1;
    @(posedge clk); #1 spike_ready = 1'b0;
    check("full_push_with_pop", 32'(drop_sticky), 0);
    wait_done();
    check("drop_sticky_set", 32'(drop_sticky), 1);
    spike_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1 check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_valid", 32'(spike_valid), 0);
    $display("fifo sequence drop_sticky=%0d", drop_sticky);
`endif

    // Tick held high for 12 cycles: two sweeps, period N+2.
    begin
      int starts;
      logic prev_busy;
      do_reset();
      starts = 0; prev_busy = 1'b0;
      tick = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 13; c++) begin
        int k;
        k = c + 1;
        @(negedge clk);
        check("held_busy", 32'(busy), 32'(((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 1 : 0));
        check("held_done", 32'(sweep_done), 32'((k == 5 || k == 11) ? 1 : 0));
        if (busy && !prev_busy) starts++;
        prev_busy = busy;
        if (c == 11) tick = 1'b0;
      end
      check("held_starts", 32'(starts), 2);
      $display("held tick sweeps=%0d", starts);
      @(posedge clk); #1;
    end

    // Reset in the middle of a sweep clears state, current and FIFO.
    do_reset();
    spike_ready = 1'b0;
    write_cur(2'd0, 8'd255);
    write_cur(2'd1, 8'd100);
    run_sweep();
    check("pre_rst_valid", 32'(spike_valid), 1);
    check_state(2'd1, 8'd100, "pre_rst_state");
    tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_valid", 32'(spike_valid), 0);
    check("midrst_state", 32'(state_mon), 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0; spike_ready = 1'b1;
    run_sweep();
    check_state(2'd1, 8'd0, "post_rst_state");
    check("post_rst_valid", 32'(spike_valid), 0);
    $display("mid-sweep reset state1=%0d", state_mon);

`ifdef LIF_SCHED_REFRACTORY_EN
    // Refractory: a firing neuron sits out the next two sweeps.
    do_reset();
    threshold = 8'd100;
    write_cur(2'd2, 8'd255);
    for (int s = 1; s <= 8; s++) begin
      if (s % 3 == 1) exp_q.push_back(2);
      run_sweep();
      check_state(2'd2, 8'd0, "refrac_state");
      check("refrac_drained", 32'(exp_q.size()), 0);
      $display("refrac sweep %0d", s);
    end
`endif

    check("final_queue", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_sched.md
# lif_sched

Time-multiplexed scheduler for leaky integrate-and-fire neurons. One shared LIF update datapath serves `N_NEURONS` virtual neurons; membrane state and input current for each neuron live in local register files. A `tick` starts one sweep that updates every neuron once. Spike events leave through a small valid/ready FIFO toward the top-level IO wrapper.

## Interface
- `N_NEURONS`, 4: virtual neurons; power of two, 2..16.
- `WIDTH`, 8: membrane, current and threshold width.
- `LEAK_SHIFT`, 1: leak per update is `state >> LEAK_SHIFT`.
- `FIFO_DEPTH`, 4: spike FIFO entries; power of two.
- `REFRAC_SWEEPS`, 2: refractory length in sweeps. Used only with `LIF_SCHED_REFRACTORY_EN`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `tick`  in  1: start one sweep. Ignored while `busy` is high.
- `cfg_we`  in  1: write enable for `cur[cfg_addr]`.
- `cfg_addr`  in  log2(N): neuron index for config write and state monitor.
- `cfg_data`  in  WIDTH: input current value to write.
- `threshold`  in  WIDTH: firing threshold, sampled per update.
- `busy`  out  1: high while a sweep is in progress.
- `sweep_done`  out  1: one-cycle pulse after the last neuron is updated.
- `spike_valid`  out  1: FIFO not empty.
- `spike_ready`  in  1: consumer pop.
- `spike_id`  out  log2(N): index of the neuron at the FIFO head.
- `state_mon`  out  WIDTH: `state[cfg_addr]`, combinational read.
- `drop_sticky`  out  1: set when a spike is lost to a full FIFO; cleared only by `rst`.

## Operation
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP on `tick`; the index counter `idx` is set to 0.
  - SWEEP updates neuron `idx` each cycle and increments `idx`. After neuron N-1 it goes to DONE.
  - DONE asserts `sweep_done` for one cycle, then returns to IDLE.
- Update for neuron i, in one cycle with write-back at the cycle-ending edge:
  - `leaked = state - (state >> LEAK_SHIFT)`.
  - `sum = leaked + cur[i]`, computed at WIDTH+1 bits, then saturated to 2^WIDTH-1.
  - If `sum >= threshold`: push i into the FIFO and set `state[i] <= 0`.
  - Otherwise: `state[i] <= sum`.
- A `threshold` value of 0 makes every update fire.
- FIFO full on a push:
  - With a same-cycle pop: the push is accepted.
  - Without a pop: the spike is dropped, `drop_sticky` is set, and the state still resets to 0.
- Config write to the neuron being updated in the same cycle: the update uses the old current; the new value applies from the next sweep.
- `tick` during SWEEP or DONE is ignored and not queued.
- `rst` asserted mid-sweep:
  - Immediate return to IDLE.
  - All `state`, `cur` and refractory counters cleared.
  - FIFO emptied.

## Timing
- Reset values: `busy`=0, `sweep_done`=0, `spike_valid`=0, `spike_id`=0, `state_mon`=0, `drop_sticky`=0.
- `tick` sampled high at edge E0:
  - `busy` is high for cycles E0+1 .. E0+N.
  - Neuron i is written at edge E0+1+i.
  - `sweep_done` is high for cycle E0+N+1.
- A spike from neuron i appears on `spike_valid`/`spike_id` in the cycle after edge E0+1+i, if the FIFO was empty.
- Pop happens at an edge where `spike_valid && spike_ready`. `spike_id` is stable while `spike_valid` is high and `spike_ready` is low.
- Minimum sweep period is N+2 cycles, tick edge to next accepted tick edge.

## Configuration
- `LIF_SCHED_REFRACTORY_EN` defined:
  - Each neuron gets a counter. A spike loads it with `REFRAC_SWEEPS`.
  - While the counter is non-zero, the update skips integration (state held at 0, no spike) and decrements the counter.
- `LIF_SCHED_REFRACTORY_EN` undefined:
  - No counters are built.
  - A neuron may fire on consecutive sweeps.

## Structure
- Shared package `lif_pkg`:
  - FSM state enum `lif_sched_state_e`.
  - Default `WIDTH` and `LEAK_SHIFT` constants.
  - Saturating-add helper function.
- Sub-module `lif_spike_fifo`: synchronous FIFO, parameterised by depth and data width, with full/empty flags and same-cycle push/pop when full.
- Everything else stays in `lif_sched`.

## Test plan
Defaults apply: N=4, WIDTH=8, LEAK_SHIFT=1, `threshold`=200.
- Reset then idle: all outputs 0; no `tick` → `busy` stays 0 for 20 cycles.
- `cur[0]`=128, three ticks, `spike_ready`=1:
  - `state[0]` is 128 after sweep 1 and 192 after sweep 2.
  - Sweep 3 gives sum 224 → spike with `spike_id`=0 and `state[0]`=0.
- `cur[1]`=255, `threshold`=255, `state[1]` preloaded via sweeps: sum saturates to 255 and fires; no wrap to a small value.
- All `cur`=255, `threshold`=1, `spike_ready`=0, two sweeps:
  - FIFO holds ids 0,1,2,3 in order.
  - Second sweep sets `drop_sticky`=1.
- `tick` held high for 12 cycles: exactly two sweeps start, at cycles 0 and 6; `sweep_done` pulses at 5 and 11.
- Refractory, with `LIF_SCHED_REFRACTORY_EN` and `REFRAC_SWEEPS`=2:
  - `cur[2]`=255, `threshold`=100.
  - Spikes occur on sweeps 1, 4 and 7 only.
